// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the RV front end.
package rv_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, EX redirect and decode handshake.
interface instruction_fetch_if;
  import rv_pipe_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic            fetch_fault;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched {instr, pc} entries; push and pop may coincide when full.
module fetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign head_o  = mem_q[rdPtr_q];

  // Flush wins over any push/pop in the same cycle.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, redirect handling with misalignment fault, queue and decode-side muxing.
module instruction_fetch
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            qFull, qEmpty, pop, push;
  fetch_entry_t    head, wdata;

  assign bus.imem_addr = pc_q;
  assign pop   = ~qEmpty & bus.id_ready;
  assign push  = ~fault_q & ~bus.redirect_valid & (~qFull | pop);
  assign wdata = '{instr: bus.imem_rdata, pc: pc_q};

  // A misaligned target is rounded down and fetching stalls until a clean redirect.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      fault_d = (bus.redirect_pc[1:0] != 2'b00);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wdata),
    .head_o  (head),
    .full_o  (qFull),
    .empty_o (qEmpty)
  );

  assign bus.id_valid    = ~qEmpty;
  assign bus.id_instr    = qEmpty ? NOP_INSTR : head.instr;
  assign bus.id_pc       = qEmpty ? '0 : head.pc;
  assign bus.id_pc_plus4 = qEmpty ? '0 : head.pc + 32'd4;
  assign bus.fetch_fault = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios followed by randomized traffic.
module tb_instruction_fetch;
  import rv_pipe_pkg::*;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        idReady = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0]  mPc = '0;
  logic         mFault = 1'b0;
  logic         monActive = 1'b0;
  fetch_entry_t sbq[$];

  instruction_fetch_if ifc();
  instruction_fetch_if ifc2();

  always #5 clk = ~clk;

  function automatic logic [31:0] memAt(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00a0_0293;
      32'h4:   return 32'h0000_0313;
      32'h8:   return 32'h0000_0393;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign ifc.imem_rdata     = memAt(ifc.imem_addr);
  assign ifc.redirect_valid = rv;
  assign ifc.redirect_pc    = rpc;
  assign ifc.id_ready       = idReady;

  assign ifc2.imem_rdata     = memAt(ifc2.imem_addr);
  assign ifc2.redirect_valid = 1'b0;
  assign ifc2.redirect_pc    = '0;
  assign ifc2.id_ready       = 1'b1;

  instruction_fetch #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dutWrap (
    .clk (clk),
    .rst (rst),
    .bus (ifc2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] p, input logic rdy);
    @(posedge clk);
    #1;
    rst     = r;
    rv      = v;
    rpc     = p;
    idReady = rdy;
  endtask

  // Reference model: what the fetch stage holds after each edge, from the behavioural rules.
  always @(posedge clk) begin
    if (rst) begin
      sbq.delete();
      mPc       = 32'h0;
      mFault    = 1'b0;
      monActive = 1'b1;
    end else if (monActive) begin
      if (rv) begin
        sbq.delete();
        mPc    = {rpc[31:2], 2'b00};
        mFault = (rpc[1:0] != 2'b00);
      end else if (!mFault && sbq.size() < QD) begin
        sbq.push_back('{instr: memAt(mPc), pc: mPc});
        mPc = mPc + 32'd4;
      end
    end
  end

  // Monitor: compare the decode-side view against the scoreboard head each cycle.
  always @(negedge clk) begin
    if (monActive) begin
      checkOutput("imem_addr", ifc.imem_addr, mPc);
      checkOutput("fetch_fault", {31'b0, ifc.fetch_fault}, {31'b0, mFault});
      if (sbq.size() > 0) begin
        checkOutput("id_valid", {31'b0, ifc.id_valid}, 32'd1);
        checkOutput("id_instr", ifc.id_instr, sbq[0].instr);
        checkOutput("id_pc", ifc.id_pc, sbq[0].pc);
        checkOutput("id_pc_plus4", ifc.id_pc_plus4, sbq[0].pc + 32'd4);
        if (idReady) void'(sbq.pop_front());
      end else begin
        checkOutput("id_valid_idle", {31'b0, ifc.id_valid}, 32'd0);
        checkOutput("id_instr_idle", ifc.id_instr, NOP_INSTR);
        checkOutput("id_pc_idle", ifc.id_pc, 32'h0);
        checkOutput("id_pc_plus4_idle", ifc.id_pc_plus4, 32'h0);
      end
    end
  end

  // Wrap instance runs with decode always ready from the first reset release.
  initial begin
    @(negedge rst);
    @(negedge clk);
    checkOutput("wrap_valid0", {31'b0, ifc2.id_valid}, 32'd0);
    checkOutput("wrap_addr0", ifc2.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    checkOutput("wrap_pc1", ifc2.id_pc, 32'hFFFF_FFF8);
    checkOutput("wrap_plus4_1", ifc2.id_pc_plus4, 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrap_pc2", ifc2.id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4_2", ifc2.id_pc_plus4, 32'h0);
    @(negedge clk);
    checkOutput("wrap_pc3", ifc2.id_pc, 32'h0);
    checkOutput("wrap_instr3", ifc2.id_instr, 32'h00a0_0293);
  end

  initial begin
    logic        r, v, rdy;
    logic [31:0] p;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    repeat (7) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h2C, 0);
    repeat (4) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h32, 1);
    repeat (6) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h40, 1);
    repeat (4) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'hFFFF_FFF0, 1);
    repeat (6) applyStimulus(0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 32'h80, 1);
    repeat (4) applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(199) == 0);
      v   = ($urandom_range(99) < 6);
      rdy = ($urandom_range(99) < 70);
      p   = $urandom & 32'h0000_00FF;
      if ($urandom_range(3) != 0) p[1:0] = 2'b00;
      if ($urandom_range(9) == 0) p = 32'hFFFF_FFF0 | {28'h0, p[3:0]};
      applyStimulus(r, v, p, rdy);
    end
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
